// File: rtl/ball_motion_if.sv
// Signal bundle between the collision/scoring logic and the ball movement engine.
// frame_tick is a one-clock strobe and bounce is sampled every clock; neither has backpressure.
interface ball_motion_if;
    logic       frame_tick;
    logic [1:0] bounce;
    logic [9:0] ball_pos_x;
    logic [9:0] ball_pos_y;
    logic [7:0] ball_size_x;
    logic [7:0] ball_size_y;
    logic       ball_dir_x;
    logic       ball_dir_y;
    logic [3:0] ball_speed_x;
    logic       in_play;
    logic       state_dbg;

    modport master (
        output frame_tick, bounce,
        input  ball_pos_x, ball_pos_y, ball_size_x, ball_size_y,
        input  ball_dir_x, ball_dir_y, ball_speed_x, in_play, state_dbg
    );

    modport slave (
        input  frame_tick, bounce,
        output ball_pos_x, ball_pos_y, ball_size_x, ball_size_y,
        output ball_dir_x, ball_dir_y, ball_speed_x, in_play, state_dbg
    );
endinterface

// File: rtl/ball_motion.sv
// Ball movement engine: serve hold at centre, per-frame stepping with edge clamping,
// direction-qualified paddle/wall reflection and paddle speed-up.
module ball_motion #(
    parameter int SCREEN_X     = 640,
    parameter int SCREEN_Y     = 480,
    parameter int BALL_SIZE_X  = 8,
    parameter int BALL_SIZE_Y  = 8,
    parameter int INIT_SPEED_X = 2,
    parameter int MAX_SPEED_X  = 6,
    parameter int SPEED_Y      = 2,
    parameter int SERVE_FRAMES = 60
) (
    input logic          clock,
    input logic          reset_n,
    ball_motion_if.slave bus
);
    typedef enum logic {ST_SERVE = 1'b0, ST_PLAY = 1'b1} state_t;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [10:0]      SCR_X   = 11'(SCREEN_X);
    localparam logic [10:0]      SCR_Y   = 11'(SCREEN_Y);
    localparam logic [10:0]      SZ_X    = 11'(BALL_SIZE_X);
    localparam logic [10:0]      SZ_Y    = 11'(BALL_SIZE_Y);
    localparam logic [10:0]      HALF_X  = 11'(SCREEN_X / 2);
    localparam logic [10:0]      HALF_Y  = 11'(SCREEN_Y / 2);
    localparam logic [9:0]       CTR_X   = 10'((SCREEN_X - BALL_SIZE_X) / 2);
    localparam logic [9:0]       CTR_Y   = 10'((SCREEN_Y - BALL_SIZE_Y) / 2);
    localparam logic [3:0]       SPD_INI = 4'(INIT_SPEED_X);
    localparam logic [3:0]       SPD_MAX = 4'(MAX_SPEED_X);
    localparam logic [3:0]       SPD_Y   = 4'(SPEED_Y);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SERVE_FRAMES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       pos_x_q, pos_x_d;
    logic [9:0]       pos_y_q, pos_y_d;
    logic             dir_x_q, dir_x_d;
    logic             dir_y_q, dir_y_d;
    logic [3:0]       speed_q, speed_d;
    logic             in_play_q, in_play_d;

    // 11-bit intermediates so pos + size + step cannot overflow before the compare.
    function automatic logic [9:0] step_pos(input logic [9:0] pos, input logic dir,
                                            input logic [3:0] step, input logic [10:0] size,
                                            input logic [10:0] screen);
        logic [10:0] p;
        logic [10:0] s;
        p = {1'b0, pos};
        s = {7'd0, step};
        if (dir) begin
            if (p + size + s > screen) step_pos = 10'(screen - size);
            else                       step_pos = 10'(p + s);
        end else begin
            if (p < s) step_pos = 10'd0;
            else       step_pos = 10'(p - s);
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        speed_d   = speed_q;
        in_play_d = in_play_q;
        case (state_q)
            ST_SERVE: begin
                if (bus.frame_tick) begin
                    if (cnt_q == CNT_END) begin
                        state_d   = ST_PLAY;
                        cnt_d     = '0;
                        in_play_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (bus.bounce == 2'd3) begin
                    state_d   = ST_SERVE;
                    cnt_d     = '0;
                    pos_x_d   = CTR_X;
                    pos_y_d   = CTR_Y;
                    dir_x_d   = ~dir_x_q;
                    speed_d   = SPD_INI;
                    in_play_d = 1'b0;
                end else begin
                    // Direction qualification ignores repeat events while the ball still overlaps.
                    if (bus.bounce == 2'd1) begin
                        if (({1'b0, pos_x_q} < HALF_X) && !dir_x_q) begin
                            dir_x_d = 1'b1;
                            speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 4'd1;
                        end else if (({1'b0, pos_x_q} >= HALF_X) && dir_x_q) begin
                            dir_x_d = 1'b0;
                            speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 4'd1;
                        end
                    end else if (bus.bounce == 2'd2) begin
                        if (({1'b0, pos_y_q} < HALF_Y) && !dir_y_q)       dir_y_d = 1'b1;
                        else if (({1'b0, pos_y_q} >= HALF_Y) && dir_y_q) dir_y_d = 1'b0;
                    end
                    if (bus.frame_tick) begin
                        pos_x_d = step_pos(pos_x_q, dir_x_d, speed_d, SZ_X, SCR_X);
                        pos_y_d = step_pos(pos_y_q, dir_y_d, SPD_Y, SZ_Y, SCR_Y);
                    end
                end
            end
            default: state_d = ST_SERVE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_SERVE;
            cnt_q     <= '0;
            pos_x_q   <= CTR_X;
            pos_y_q   <= CTR_Y;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            speed_q   <= SPD_INI;
            in_play_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            speed_q   <= speed_d;
            in_play_q <= in_play_d;
        end
    end

    assign bus.ball_pos_x   = pos_x_q;
    assign bus.ball_pos_y   = pos_y_q;
    assign bus.ball_size_x  = 8'(BALL_SIZE_X);
    assign bus.ball_size_y  = 8'(BALL_SIZE_Y);
    assign bus.ball_dir_x   = dir_x_q;
    assign bus.ball_dir_y   = dir_y_q;
    assign bus.ball_speed_x = speed_q;
    assign bus.in_play      = in_play_q;
    assign bus.state_dbg    = (state_q == ST_PLAY);
endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: serve timing, paddle/wall qualification, speed saturation,
// scoring, clamping and asynchronous reset, all against hand-computed expectations.
module tb_ball_motion;
    logic clock;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    ball_motion_if bus ();

    ball_motion dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic       ft;
        logic [1:0] b;
        logic [9:0] x;
        logic [9:0] y;
        logic       dx;
        logic       dy;
        logic [3:0] spd;
        logic       inp;
    } vec_t;

    vec_t tbl_a[6];
    vec_t tbl_b[9];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs are applied at a falling edge; outputs are sampled at the next falling edge.
    task automatic cycle(input logic ft, input logic [1:0] b);
        bus.frame_tick = ft;
        bus.bounce     = b;
        @(posedge clock);
        @(negedge clock);
        bus.frame_tick = 1'b0;
        bus.bounce     = 2'd0;
    endtask

    task automatic check(input string name, input logic [9:0] x, input logic [9:0] y,
                         input logic dx, input logic dy, input logic [3:0] spd, input logic inp);
        logic [27:0] act;
        logic [27:0] exp_v;
        act   = {bus.ball_pos_x, bus.ball_pos_y, bus.ball_dir_x, bus.ball_dir_y,
                 bus.ball_speed_x, bus.in_play, bus.state_dbg};
        exp_v = {x, y, dx, dy, spd, inp, inp};
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got x=%0d y=%0d dx=%b dy=%b spd=%0d in_play=%b st=%b, want x=%0d y=%0d dx=%b dy=%b spd=%0d in_play=%b st=%b",
                     name, bus.ball_pos_x, bus.ball_pos_y, bus.ball_dir_x, bus.ball_dir_y,
                     bus.ball_speed_x, bus.in_play, bus.state_dbg, x, y, dx, dy, spd, inp, inp);
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        cycle(v.ft, v.b);
        check(name, v.x, v.y, v.dx, v.dy, v.spd, v.inp);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Paddle held 3 clocks at x=600, step, wall+step, score+step.
        tbl_a[0] = '{1'b0, 2'd1, 10'd600, 10'd472, 1'b0, 1'b1, 4'd3, 1'b1};
        tbl_a[1] = '{1'b0, 2'd1, 10'd600, 10'd472, 1'b0, 1'b1, 4'd3, 1'b1};
        tbl_a[2] = '{1'b0, 2'd1, 10'd600, 10'd472, 1'b0, 1'b1, 4'd3, 1'b1};
        tbl_a[3] = '{1'b1, 2'd0, 10'd597, 10'd472, 1'b0, 1'b1, 4'd3, 1'b1};
        tbl_a[4] = '{1'b1, 2'd2, 10'd594, 10'd470, 1'b0, 1'b0, 4'd3, 1'b1};
        tbl_a[5] = '{1'b1, 2'd3, 10'd316, 10'd236, 1'b1, 1'b0, 4'd2, 1'b0};

        // Oscillate around x=320 so every paddle hit is accepted: speed 3,4,5,6,6,6.
        tbl_b[0] = '{1'b1, 2'd0, 10'd318, 10'd234, 1'b1, 1'b0, 4'd2, 1'b1};
        tbl_b[1] = '{1'b1, 2'd0, 10'd320, 10'd232, 1'b1, 1'b0, 4'd2, 1'b1};
        tbl_b[2] = '{1'b1, 2'd1, 10'd317, 10'd230, 1'b0, 1'b0, 4'd3, 1'b1};
        tbl_b[3] = '{1'b1, 2'd1, 10'd321, 10'd228, 1'b1, 1'b0, 4'd4, 1'b1};
        tbl_b[4] = '{1'b1, 2'd1, 10'd316, 10'd226, 1'b0, 1'b0, 4'd5, 1'b1};
        tbl_b[5] = '{1'b1, 2'd1, 10'd322, 10'd224, 1'b1, 1'b0, 4'd6, 1'b1};
        tbl_b[6] = '{1'b1, 2'd1, 10'd316, 10'd222, 1'b0, 1'b0, 4'd6, 1'b1};
        tbl_b[7] = '{1'b1, 2'd1, 10'd322, 10'd220, 1'b1, 1'b0, 4'd6, 1'b1};
        tbl_b[8] = '{1'b1, 2'd1, 10'd316, 10'd218, 1'b0, 1'b0, 4'd6, 1'b1};

        reset_n        = 1'b0;
        bus.frame_tick = 1'b0;
        bus.bounce     = 2'd0;
        repeat (3) @(negedge clock);
        check("reset", 10'd316, 10'd236, 1'b1, 1'b1, 4'd2, 1'b0);
        tests_run++;
        if (bus.ball_size_x !== 8'd8 || bus.ball_size_y !== 8'd8) begin
            tests_failed++;
            $display("FAIL size: got %0d x %0d, want 8 x 8", bus.ball_size_x, bus.ball_size_y);
        end
        reset_n = 1'b1;

        // Serve: 59 ticks hold, tick 60 enters play without stepping, tick 61 steps.
        for (int i = 0; i < 59; i++) cycle(1'b1, 2'd0);
        check("serve_t59", 10'd316, 10'd236, 1'b1, 1'b1, 4'd2, 1'b0);
        cycle(1'b1, 2'd0);
        check("serve_t60", 10'd316, 10'd236, 1'b1, 1'b1, 4'd2, 1'b1);
        cycle(1'b1, 2'd0);
        check("serve_t61", 10'd318, 10'd238, 1'b1, 1'b1, 4'd2, 1'b1);

        // Travel right; y reaches 472 and then clamps there.
        for (int i = 0; i < 141; i++) cycle(1'b1, 2'd0);
        check("travel_600", 10'd600, 10'd472, 1'b1, 1'b1, 4'd2, 1'b1);

        for (int i = 0; i < 6; i++) run_vec($sformatf("tbl_a[%0d]", i), tbl_a[i]);

        // Serve after score: bounce=3 held with and without ticks has no effect.
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'd3);
        check("serve_b3_tick", 10'd316, 10'd236, 1'b1, 1'b0, 4'd2, 1'b0);
        cycle(1'b0, 2'd3);
        check("serve_b3_idle", 10'd316, 10'd236, 1'b1, 1'b0, 4'd2, 1'b0);
        for (int i = 0; i < 54; i++) cycle(1'b1, 2'd0);
        check("reserve_t59", 10'd316, 10'd236, 1'b1, 1'b0, 4'd2, 1'b0);
        cycle(1'b1, 2'd0);
        check("reserve_t60", 10'd316, 10'd236, 1'b1, 1'b0, 4'd2, 1'b1);

        for (int i = 0; i < 9; i++) run_vec($sformatf("tbl_b[%0d]", i), tbl_b[i]);

        // Leftward at speed 6 from 316: 52 ticks to x=4, then one clamped step to 0.
        for (int i = 0; i < 52; i++) cycle(1'b1, 2'd0);
        check("travel_left", 10'd4, 10'd114, 1'b0, 1'b0, 4'd6, 1'b1);
        cycle(1'b1, 2'd0);
        check("clamp_x0", 10'd0, 10'd112, 1'b0, 1'b0, 4'd6, 1'b1);

        // Asynchronous reset between clock edges.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", 10'd316, 10'd236, 1'b1, 1'b1, 4'd2, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        cycle(1'b0, 2'd3);
        check("post_reset", 10'd316, 10'd236, 1'b1, 1'b1, 4'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
